// File: rtl/demux8_16bit_buf.sv
// ---------------------------------------------------------------------------
// demux8_16bit_buf
//
// Purpose:
//   Routes a stream of WIDTH-bit words from one source to eight buffered
//   output channels (A..H). Each channel owns a single holding register and
//   a valid bit. A channel is written only when it is empty, or when its
//   consumer takes the current word in the same cycle, so a refill can follow
//   an ack without a bubble. Accepted words are counted. An ack on an empty
//   channel sets a sticky error flag.
//
// Ports:
//   clk              rising-edge clock for all state
//   rst_n            asynchronous active-low reset
//   in_valid         source offers in_data this cycle
//   in_sel[2:0]      destination channel index (0 = A ... 7 = H)
//   in_data          offered word
//   in_ready         addressed channel can take the word this cycle
//   out_a..out_h     channel holding registers
//   out_valid[7:0]   bit i set = channel i holds an unconsumed word
//   out_ack[7:0]     bit i = consumer of channel i takes its word
//   accept_cnt[15:0] count of accepted words, wraps at 16 bits
//   ack_err          sticky flag for an ack seen on an empty channel
//
// CHANNELS is fixed at 8 because the select is 3 bits and the outputs are
// named individually. It is kept as a parameter for documentation and for
// sizing the internal storage.
// ---------------------------------------------------------------------------
module demux8_16bit_buf #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_e,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_h,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ack,
    output logic [15:0]      accept_cnt,
    output logic             ack_err
);

    logic [WIDTH-1:0] data_r [CHANNELS];
    logic [7:0]       valid_r;
    logic [15:0]      cnt_r;
    logic             err_r;

    logic             ready_s;
    logic             accept_s;
    logic [7:0]       load_s;
    logic [7:0]       valid_nxt_s;
    logic             spurious_s;

    // Handshake decode: readiness of the addressed channel, load strobe, next valid bits
    always_comb begin
        ready_s     = ~valid_r[in_sel] | out_ack[in_sel];
        accept_s    = in_valid & ready_s;
        load_s      = 8'h00;
        if (accept_s) begin
            load_s[in_sel] = 1'b1;
        end else begin
            load_s = 8'h00;
        end
        // A load on the same edge as an ack wins, so the channel stays valid.
        valid_nxt_s = load_s | (valid_r & ~out_ack);
        spurious_s  = |(out_ack & ~valid_r);
    end

    // Channel holding registers: change only when a word is accepted for them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= in_data;
                end else begin
                    data_r[i] <= data_r[i];
                end
            end
        end
    end

    // Channel valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 8'h00;
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    // Accepted-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'h0000;
        end else if (accept_s) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky error for an ack on an empty channel; cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (spurious_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign in_ready   = ready_s;
    assign out_a      = data_r[0];
    assign out_b      = data_r[1];
    assign out_c      = data_r[2];
    assign out_d      = data_r[3];
    assign out_e      = data_r[4];
    assign out_f      = data_r[5];
    assign out_g      = data_r[6];
    assign out_h      = data_r[7];
    assign out_valid  = valid_r;
    assign accept_cnt = cnt_r;
    assign ack_err    = err_r;

endmodule

// File: tb/tb_demux8_16bit_buf.sv
// ---------------------------------------------------------------------------
// tb_demux8_16bit_buf
//
// Self-checking bench for demux8_16bit_buf. A channel-level reference model
// (word array, valid bitmap, counter, error flag) predicts every output. The
// bench runs directed scenarios first: basic write, backpressure, a sweep of
// all channels, a spurious ack, an async reset, and counter wrap. A randomized
// phase follows.
// ---------------------------------------------------------------------------
module tb_demux8_16bit_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_sel;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ack;
    logic [15:0] accept_cnt;
    logic        ack_err;

    logic [15:0] obs_data [8];

    // Reference model state
    logic [15:0] m_data [8];
    logic [7:0]  m_valid;
    logic [15:0] m_cnt;
    logic        m_err;

    int errors = 0;
    int checks = 0;

    demux8_16bit_buf #(.WIDTH(16), .CHANNELS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .out_e      (out_e),
        .out_f      (out_f),
        .out_g      (out_g),
        .out_h      (out_h),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .accept_cnt (accept_cnt),
        .ack_err    (ack_err)
    );

    assign obs_data[0] = out_a;
    assign obs_data[1] = out_b;
    assign obs_data[2] = out_c;
    assign obs_data[3] = out_d;
    assign obs_data[4] = out_e;
    assign obs_data[5] = out_f;
    assign obs_data[6] = out_g;
    assign obs_data[7] = out_h;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_data[i] = 16'h0000;
        m_valid = 8'h00;
        m_cnt   = 16'h0000;
        m_err   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".accept_cnt"}, 32'(accept_cnt), 32'(m_cnt));
        chk({tag, ".ack_err"}, 32'(ack_err), 32'(m_err));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.out[%0d]", tag, i), 32'(obs_data[i]), 32'(m_data[i]));
        end
    endtask

    // One clock cycle of stimulus: drive, check ready, clock, update model, check state
    task automatic step(input logic v, input logic [2:0] s, input logic [15:0] d,
                        input logic [7:0] a, input bit do_chk);
        logic       exp_ready;
        logic       acc;
        logic [7:0] bad;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        out_ack  = a;
        #1;
        exp_ready = !m_valid[s] || a[s];
        if (do_chk) chk("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        bad = a & ~m_valid;
        acc = v && exp_ready;
        for (int i = 0; i < 8; i++) begin
            if (acc && (32'(s) == i)) begin
                m_data[i]  = d;
                m_valid[i] = 1'b1;
            end else if (a[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        if (acc) m_cnt = m_cnt + 16'h0001;
        if (|bad) m_err = 1'b1;
        #1;
        if (do_chk) check_all("step");
    endtask

    // Assert reset in the middle of a cycle and confirm outputs clear without a clock edge
    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        out_ack  = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_all({tag, ".hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 3'd0;
        in_data  = 16'h0000;
        out_ack  = 8'h00;
        model_reset();
        #3;
        check_all("por");
        chk("por.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic write to channel F
        step(1'b1, 3'd5, 16'hBEEF, 8'h00, 1'b1);
        chk("basic.out_f", 32'(out_f), 32'h0000BEEF);
        chk("basic.out_valid", 32'(out_valid), 32'h20);
        chk("basic.cnt", 32'(accept_cnt), 32'd1);

        // Backpressure on channel C
        step(1'b1, 3'd2, 16'h1111, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'd2, 16'h2222, 8'h00, 1'b1);
            chk("bp.out_c", 32'(out_c), 32'h00001111);
            chk("bp.cnt", 32'(accept_cnt), 32'd2);
        end
        in_ack_probe: begin
            in_valid = 1'b1; in_sel = 3'd2; in_data = 16'h2222; out_ack = 8'h00;
            #1;
            chk("bp.stall_ready", 32'(in_ready), 32'd0);
        end
        step(1'b1, 3'd2, 16'h2222, 8'h04, 1'b1);
        chk("bp.refill_c", 32'(out_c), 32'h00002222);
        chk("bp.refill_valid", 32'(out_valid[2]), 32'd1);
        chk("bp.refill_cnt", 32'(accept_cnt), 32'd3);

        // Sweep all eight channels back to back from a clean state
        do_reset("rst1");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 16'(i), 8'h00, 1'b1);
            chk("sweep.in_ready_model", 32'(m_cnt), 32'(i + 1));
        end
        chk("sweep.out_valid", 32'(out_valid), 32'hFF);
        chk("sweep.cnt", 32'(accept_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sweep.out[%0d]", i), 32'(obs_data[i]), 32'(i));
        end

        // Consume channel A, then ack it again while empty
        step(1'b0, 3'd0, 16'h0000, 8'h01, 1'b1);
        chk("spur.pre_err", 32'(ack_err), 32'd0);
        step(1'b0, 3'd0, 16'h0000, 8'h01, 1'b1);
        chk("spur.err", 32'(ack_err), 32'd1);
        chk("spur.out_valid", 32'(out_valid), 32'hFE);
        step(1'b0, 3'd0, 16'h0000, 8'h00, 1'b1);
        chk("spur.sticky", 32'(ack_err), 32'd1);

        // Leave channels C..F occupied, then reset mid-cycle
        step(1'b0, 3'd0, 16'h0000, 8'hC3, 1'b1);
        chk("arst.pre_valid", 32'(out_valid), 32'h3C);
        do_reset("arst");
        step(1'b1, 3'd3, 16'hA5A5, 8'h00, 1'b1);
        chk("arst.post_d", 32'(out_d), 32'h0000A5A5);
        chk("arst.post_cnt", 32'(accept_cnt), 32'd1);

        // Counter wrap: 65536 accepted words, every channel acked every cycle
        do_reset("rst2");
        for (int k = 0; k < 65536; k++) begin
            step(1'b1, 3'(k), 16'(k), 8'hFF, 1'b0);
        end
        chk("wrap.cnt", 32'(accept_cnt), 32'd0);
        check_all("wrap");

        // Randomized traffic against the model
        do_reset("rst3");
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 16'($urandom), 8'($urandom & $urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux8_16bit_buf.md
DEMUX8_16BIT_BUF -- requirements
Module: demux8_16bit_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the data word width.
REQ-002 SHALL have parameter CHANNELS, default 8, the number of output channels, fixed at 8 and addressed by a 3-bit select.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, source offers a word this cycle.
REQ-006 SHALL have port in_sel, input, 3, destination channel index (0 = A ... 7 = H).
REQ-007 SHALL have port in_data, input, WIDTH, offered word.
REQ-008 SHALL have port in_ready, output, 1, block can accept the offered word this cycle.
REQ-009 SHALL have ports out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h, each output, WIDTH, holding register of the channel.
REQ-010 SHALL have port out_valid, output, 8, bit i set = channel i holds an unconsumed word.
REQ-011 SHALL have port out_ack, input, 8, bit i = consumer of channel i takes its word this cycle.
REQ-012 SHALL have port accept_cnt, output, 16, count of accepted input words.
REQ-013 SHALL have port ack_err, output, 1, sticky flag for an ack on an empty channel.

Function
REQ-014 SHALL drive in_ready combinationally as ~out_valid[in_sel] | out_ack[in_sel].
- in_ready depends only on the addressed channel.
- in_ready does not depend on in_valid.
REQ-015 SHALL treat a word as accepted when in_valid & in_ready are both high at a clock edge.
- At that edge, channel in_sel register <= in_data and out_valid[in_sel] <= 1.
- Data is visible one cycle after acceptance.
REQ-016 SHALL clear out_valid[i] at an edge where out_ack[i] & out_valid[i], unless the same edge accepts a word for channel i.
- If both happen, out_valid[i] stays 1 and the register takes the new word (pass-through refill, no bubble).
REQ-017 SHALL leave each channel register unchanged except on acceptance for that channel.
- Register contents persist after ack (out_valid low, data stale).
REQ-018 SHALL never overwrite a channel whose out_valid is 1 and out_ack is 0.
- A source holding in_valid high while stalled SHALL keep in_data and in_sel stable; the block accepts when the channel frees.
REQ-019 SHALL process multiple out_ack bits in the same cycle independently.
REQ-020 SHALL ignore out_ack[i] when out_valid[i] = 0, except that it sets ack_err to 1.
- ack_err stays 1 until reset.
REQ-021 SHALL increment accept_cnt by 1 per accepted word, wrapping from 16'hFFFF to 0.
REQ-022 SHALL accept at most one word per cycle; sustained throughput SHALL be 1 word per cycle when destination channels are free or acked.
REQ-023 SHALL ignore in_sel and in_data when in_valid = 0 (no state change).

Reset
REQ-024 SHALL, while rst_n = 0, force all of the following regardless of clk:
- out_a..out_h = 0
- out_valid = 8'h00
- accept_cnt = 0
- ack_err = 0
REQ-025 SHALL, on assertion mid-transfer, discard all buffered words with no partial update.
- First acceptance possible at the first rising edge after rst_n returns high.
REQ-026 SHALL drive in_ready = 1 during and after reset while all channels are empty.

Verification
REQ-027 Bench SHALL cover basic write:
- Stimulus: in_sel = 5, in_data = 16'hBEEF, in_valid for 1 cycle.
- Response: next cycle out_f = 16'hBEEF, out_valid = 8'h20, accept_cnt = 1.
REQ-028 Bench SHALL cover backpressure:
- Stimulus: channel 2 full with 16'h1111, no ack; offer 16'h2222 to channel 2 for 3 cycles.
- Response: in_ready = 0 throughout, out_c stays 16'h1111, accept_cnt unchanged.
- Then assert out_ack[2]: 16'h2222 is accepted that edge and out_valid[2] stays 1.
REQ-029 Bench SHALL cover all-channel sweep:
- Stimulus: 8 back-to-back words 16'h0000..16'h0007 to sel 0..7.
- Response: out_valid = 8'hFF, out_a..out_h = 0..7, accept_cnt = 8, in_ready = 1 on every cycle.
REQ-030 Bench SHALL cover spurious ack:
- Stimulus: out_ack = 8'h01 with channel 0 empty.
- Response: ack_err = 1 thereafter, out_valid unchanged.
REQ-031 Bench SHALL cover counter wrap:
- Stimulus: 65536 accepted words.
- Response: accept_cnt returns to 0.
REQ-032 Bench SHALL cover async reset:
- Stimulus: assert rst_n low mid-cycle with out_valid = 8'h3C.
- Response: outputs clear immediately without a clock edge; first post-reset write is accepted normally.
